tetris_input_scheduler: RTL and testbench

//  Sits between the PS/2 event stream and the game FSM. Tracks make/break state
//  for six game keys and turns presses into one-shot commands. LEFT/RIGHT/DOWN

---
 rtl/tetris_input_scheduler.sv | 126 ++++++++++++
 tb/tb_tetris_input_scheduler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tetris_input_scheduler.sv
// Six-key PS/2 input scheduler: per-key make/break FSMs with DAS/ARR auto-repeat,
// single-depth pending bits and a fixed-priority valid/ready command port.
module tetris_input_scheduler #(
  parameter logic [7:0]  LEFT_C     = 8'h6B,
  parameter logic [7:0]  RIGHT_C    = 8'h74,
  parameter logic [7:0]  DOWN_C     = 8'h72,
  parameter logic [7:0]  ROT_C      = 8'h75,
  parameter logic [7:0]  DROP_C     = 8'h29,
  parameter logic [7:0]  HOLD_C     = 8'h21,
  parameter int unsigned DAS_DELAY  = 16,
  parameter int unsigned ARR_PERIOD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       ev_valid,
  input  logic [7:0] ev_code,
  input  logic       ev_make,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  input  logic       cmd_ready
);

  localparam int unsigned NumKeys = 6;
  localparam int unsigned CntMax  = (DAS_DELAY > ARR_PERIOD) ? DAS_DELAY : ARR_PERIOD;
  localparam int unsigned CntW    = $clog2(CntMax + 1);
  localparam logic [NumKeys*8-1:0] KeyCodes = {HOLD_C, DROP_C, ROT_C, DOWN_C, RIGHT_C, LEFT_C};

  typedef enum logic [2:0] {StIdle, StPress, StDelay, StRepeat, StHeld} key_state_e;

  key_state_e          state_q [NumKeys];
  logic [CntW-1:0]     cnt_q   [NumKeys];
  logic [NumKeys-1:0]  hit;
  logic [NumKeys-1:0]  fire;
  logic [NumKeys-1:0]  pend_q;
  logic [NumKeys-1:0]  grant;
  logic                any;
  logic                load;
  logic [2:0]          win;

  always_comb begin
    hit  = '0;
    fire = '0;
    for (int k = 0; k < NumKeys; k++) begin
      hit[k]  = ev_valid && (ev_code == KeyCodes[k*8 +: 8]);
      // A break on the firing edge wins over the repeat.
      fire[k] = enable && !(hit[k] && !ev_make) &&
                ((state_q[k] == StIdle && hit[k]) ||
                 (state_q[k] == StDelay && cnt_q[k] == CntW'(DAS_DELAY - 1)) ||
                 (state_q[k] == StRepeat && cnt_q[k] == CntW'(ARR_PERIOD - 1)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NumKeys; k++) begin
        state_q[k] <= StIdle;
        cnt_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < NumKeys; k++) begin
        if (hit[k] && !ev_make) begin
          state_q[k] <= StIdle;
          cnt_q[k]   <= '0;
        end else if (!enable) begin
          // Keys down while paused park in HELD so they need a fresh press later.
          if (state_q[k] != StIdle || hit[k]) state_q[k] <= StHeld;
          cnt_q[k] <= '0;
        end else begin
          unique case (state_q[k])
            StIdle:  if (hit[k]) state_q[k] <= StPress;
            StPress: begin
              state_q[k] <= (k < 3) ? StDelay : StHeld;
              cnt_q[k]   <= '0;
            end
            StDelay: begin
              if (cnt_q[k] == CntW'(DAS_DELAY - 1)) begin
                state_q[k] <= StRepeat;
                cnt_q[k]   <= '0;
              end else begin
                cnt_q[k] <= cnt_q[k] + CntW'(1);
              end
            end
            StRepeat: begin
              if (cnt_q[k] == CntW'(ARR_PERIOD - 1)) cnt_q[k] <= '0;
              else cnt_q[k] <= cnt_q[k] + CntW'(1);
            end
            StHeld:  ;
            default: state_q[k] <= StIdle;
          endcase
        end
      end
    end
  end

  // Fixed priority: DROP > HOLD > ROTATE > LEFT > RIGHT > DOWN.
  always_comb begin
    any  = |pend_q;
    load = !cmd_valid || cmd_ready;
    if (pend_q[4])      win = 3'd4;
    else if (pend_q[5]) win = 3'd5;
    else if (pend_q[3]) win = 3'd3;
    else if (pend_q[0]) win = 3'd0;
    else if (pend_q[1]) win = 3'd1;
    else                win = 3'd2;
    grant = (load && any) ? (6'b000001 << win) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q    <= '0;
      cmd_valid <= 1'b0;
      cmd       <= 3'd0;
    end else if (!enable) begin
      pend_q    <= '0;
      cmd_valid <= 1'b0;
    end else begin
      pend_q <= (pend_q & ~grant) | fire;
      if (load) begin
        cmd_valid <= any;
        if (any) cmd <= win;
      end
    end
  end

endmodule

// File: tb/tb_tetris_input_scheduler.sv
// Directed + randomised bench: a cycle-level reference model predicts accepted commands
// (id and acceptance edge) into a queue that a separate monitor drains against the DUT.
module tb_tetris_input_scheduler;
  localparam int DAS = 4;
  localparam int ARR = 2;
  localparam logic [7:0] LEFT_C  = 8'h6B;
  localparam logic [7:0] RIGHT_C = 8'h74;
  localparam logic [7:0] DOWN_C  = 8'h72;
  localparam logic [7:0] ROT_C   = 8'h75;
  localparam logic [7:0] DROP_C  = 8'h29;
  localparam logic [7:0] HOLD_C  = 8'h21;

  logic       clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic       ev_valid = 1'b0, ev_make = 1'b0, cmd_ready = 1'b0;
  logic [7:0] ev_code = 8'h00;
  logic       cmd_valid;
  logic [2:0] cmd;

  always #5 clk = ~clk;

  tetris_input_scheduler #(
    .LEFT_C(LEFT_C), .RIGHT_C(RIGHT_C), .DOWN_C(DOWN_C), .ROT_C(ROT_C),
    .DROP_C(DROP_C), .HOLD_C(HOLD_C), .DAS_DELAY(DAS), .ARR_PERIOD(ARR)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .ev_valid(ev_valid), .ev_code(ev_code),
    .ev_make(ev_make), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready)
  );

  typedef struct {int c; int e;} exp_t;
  exp_t exp_q[$];
  int nchecks = 0, nerr = 0;

  logic [7:0] codes [6] = '{LEFT_C, RIGHT_C, DOWN_C, ROT_C, DROP_C, HOLD_C};
  int prio [6] = '{4, 5, 3, 0, 1, 2};

  // Reference model state: key held flags, press edge, armed (pressed while enabled).
  bit       m_held [6];
  int       m_press [6];
  bit       m_armed [6];
  bit [5:0] m_pend = '0;
  bit       m_valid = 1'b0;
  int       m_cmd = 0;
  int       t = 0;
  bit       rdy_v = 1'b0, en_v = 1'b0, rst_v = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, t);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 6; k++) begin
      m_held[k] = 0; m_armed[k] = 0; m_press[k] = 0;
    end
    m_pend = '0; m_valid = 0; m_cmd = 0;
  endtask

  // Predicts the effect of the coming clock edge (index t) given the inputs just driven.
  task automatic model_step();
    bit [5:0] fire;
    int win, age;
    bit hitk;
    if (rst) begin
      model_reset();
    end else begin
      if (m_valid && cmd_ready) exp_q.push_back('{c: m_cmd, e: t});
      fire = '0;
      for (int k = 0; k < 6; k++) begin
        hitk = ev_valid && (ev_code == codes[k]);
        if (hitk && !ev_make) begin
          m_held[k] = 0;
        end else if (hitk && ev_make && !m_held[k]) begin
          m_held[k] = 1; m_press[k] = t; m_armed[k] = enable; fire[k] = enable;
        end else if (m_held[k] && m_armed[k] && enable && k < 3) begin
          age = t - m_press[k];
          if (age == 1 + DAS || (age > 1 + DAS && (age - 1 - DAS) % ARR == 0)) fire[k] = 1;
        end
        if (!enable) m_armed[k] = 0;
      end
      if (!enable) begin
        m_pend = '0; m_valid = 0;
      end else begin
        if (!m_valid || cmd_ready) begin
          win = -1;
          for (int i = 0; i < 6; i++) if (win < 0 && m_pend[prio[i]]) win = prio[i];
          if (win >= 0) begin
            m_pend[win] = 0; m_valid = 1; m_cmd = win;
          end else begin
            m_valid = 0;
          end
        end
        m_pend = m_pend | fire;
      end
    end
    t++;
  endtask

  task automatic cyc(input bit v, input logic [7:0] code, input bit mk);
    @(negedge clk);
    rst = rst_v; enable = en_v; cmd_ready = rdy_v;
    ev_valid = v; ev_code = code; ev_make = mk;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 0);
  endtask

  // Monitor: pops an expectation on every DUT handshake; also checks stall stability.
  initial begin
    bit   stall;
    int   stall_cmd;
    exp_t e;
    stall = 0; stall_cmd = 0;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        stall = 0;
      end else begin
        if (stall) begin
          chk("hold_valid", cmd_valid, 1);
          chk("hold_cmd", cmd, stall_cmd);
        end
        if (cmd_valid && cmd_ready) begin
          if (exp_q.size() == 0) begin
            nchecks++; nerr++;
            $display("FAIL unexpected_cmd: got cmd %0d at edge %0d, expected none", cmd, t - 1);
          end else begin
            e = exp_q.pop_front();
            chk("cmd_id", cmd, e.c);
            chk("cmd_edge", t - 1, e.e);
          end
        end
        stall = cmd_valid && !cmd_ready && enable;
        stall_cmd = cmd;
      end
    end
  end

  initial begin
    int r;
    logic [7:0] code;
    idle(3);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_cmd", cmd, 0);
    rst_v = 0; en_v = 1; rdy_v = 1;
    idle(2);

    // 1: tap DROP
    cyc(1, DROP_C, 1); cyc(1, DROP_C, 0); idle(6);
    // 2: hold LEFT 20 cycles
    cyc(1, LEFT_C, 1); idle(19); cyc(1, LEFT_C, 0); idle(6);
    // 3: output busy with HOLD, then ROT/LEFT/DROP pend under back-pressure
    rdy_v = 0;
    cyc(1, HOLD_C, 1); cyc(1, ROT_C, 1); cyc(1, LEFT_C, 1); cyc(1, DROP_C, 1);
    cyc(1, LEFT_C, 0); idle(5);
    rdy_v = 1;
    cyc(1, HOLD_C, 0); cyc(1, ROT_C, 0); cyc(1, DROP_C, 0); idle(6);
    // 4: ROT with typematic repeats
    for (int i = 0; i < 5; i++) begin cyc(1, ROT_C, 1); idle(2); end
    cyc(1, ROT_C, 0); idle(4);
    // 5: RIGHT held, enable drops mid-REPEAT
    cyc(1, RIGHT_C, 1); idle(9);
    en_v = 0; idle(3);
    chk("paused_valid", cmd_valid, 0);
    en_v = 1; idle(10);
    cyc(1, RIGHT_C, 0); idle(2); cyc(1, RIGHT_C, 1); idle(3); cyc(1, RIGHT_C, 0); idle(5);
    // 6: async reset mid-REPEAT with a stalled command
    cyc(1, RIGHT_C, 1); idle(8);
    rdy_v = 0; idle(4);
    chk("pre_rst_valid", cmd_valid, 1);
    #3 rst = 1; rst_v = 1; model_reset();
    #1 chk("async_rst_valid", cmd_valid, 0);
    chk("async_rst_cmd", cmd, 0);
    idle(2);
    rst_v = 0; rdy_v = 1; idle(10);
    cyc(1, RIGHT_C, 1); idle(2); cyc(1, RIGHT_C, 0); idle(5);

    // Random phase
    for (int i = 0; i < 800; i++) begin
      en_v  = ($urandom_range(0, 49) != 0);
      rdy_v = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 6);
      code = (r == 6) ? 8'h1C : codes[r];
      cyc(($urandom_range(0, 2) == 0), code, ($urandom_range(0, 9) < 6));
    end

    en_v = 1; rdy_v = 1;
    for (int k = 0; k < 6; k++) cyc(1, codes[k], 0);
    idle(40);
    chk("drain_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
